// File: rtl/axonerve_kernel_ctrl.sv
// Kernel control sequencer: latches scalar arguments, kicks the selected
// engines once per run, gathers their done pulses and reports completion
// through an ap_ctrl_hs or ap_ctrl_chain handshake.  A saturating cycle
// counter measures each run, and an optional watchdog bounds the time spent
// waiting on the engines.
module axonerve_kernel_ctrl #(
    parameter int NUM_ENGINES    = 4,
    parameter int CHAIN_MODE     = 0,
    parameter int CYC_W          = 64,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   ap_clk,
    input  logic                   areset,
    input  logic                   ap_start,
    input  logic                   ap_continue,
    output logic                   ap_idle,
    output logic                   ap_ready,
    output logic                   ap_done,
    input  logic [NUM_ENGINES-1:0] engine_mask_in,
    input  logic [31:0]            data_num_in,
    input  logic [31:0]            command_in,
    input  logic [63:0]            ptr_in,
    output logic [31:0]            data_num_q,
    output logic [31:0]            command_q,
    output logic [63:0]            ptr_q,
    output logic [NUM_ENGINES-1:0] engine_kick,
    input  logic [NUM_ENGINES-1:0] engine_done,
    output logic [NUM_ENGINES-1:0] done_status,
    output logic                   timeout_err,
    output logic [CYC_W-1:0]       cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_DONE} state_t;

    // The watchdog fires in the RUN cycle whose count equals the limit, so the
    // counter is compared against limit-1 (it counts completed RUN cycles).
    localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] RUN_LIMIT = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_start_d;
    logic                   r_ready;
    logic [NUM_ENGINES-1:0] r_mask;
    logic [NUM_ENGINES-1:0] r_done_status;
    logic                   r_timeout;
    logic [CYC_W-1:0]       r_cycles;
    logic [31:0]            r_run_cnt;
    logic [31:0]            r_data_num;
    logic [31:0]            r_command;
    logic [63:0]            r_ptr;

    logic                   w_start_ev;
    logic [NUM_ENGINES-1:0] w_done_acc;
    logic                   w_all_done;
    logic                   w_wdog_hit;

    // Saturating increment so a pathological run never wraps the counter.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    // hs mode starts on a rising edge of ap_start; chain mode starts on level.
    assign w_start_ev = (CHAIN_MODE != 0) ? ap_start : (ap_start & ~r_start_d);
    assign w_done_acc = r_done_status | (engine_done & r_mask);
    assign w_all_done = ((w_done_acc & r_mask) == r_mask);
    assign w_wdog_hit = WDOG_EN && (r_run_cnt == RUN_LIMIT);

    assign data_num_q  = r_data_num;
    assign command_q   = r_command;
    assign ptr_q       = r_ptr;
    assign done_status = r_done_status;
    assign timeout_err = r_timeout;
    assign cycle_count = r_cycles;
    assign ap_ready    = r_ready;

    // State register; reset aborts any run in progress.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        engine_kick = '0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (w_start_ev) begin
                    w_state_nxt = (engine_mask_in == '0) ? S_DONE : S_KICK;
                end
            end
            S_KICK: begin
                engine_kick = r_mask;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Completion wins over a watchdog hit in the same cycle.
                if (w_all_done || w_wdog_hit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                if ((CHAIN_MODE == 0) || ap_continue) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Argument latch, done aggregation, cycle counting and watchdog.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_start_d     <= 1'b0;
            r_ready       <= 1'b0;
            r_mask        <= '0;
            r_done_status <= '0;
            r_timeout     <= 1'b0;
            r_cycles      <= '0;
            r_run_cnt     <= '0;
            r_data_num    <= '0;
            r_command     <= '0;
            r_ptr         <= '0;
        end else begin
            r_start_d <= ap_start;
            // Arguments are consumed on the accepting edge, so ready shows in
            // the following cycle whether the run goes to KICK or straight to DONE.
            r_ready   <= (r_state == S_IDLE) && w_start_ev;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ev) begin
                        r_data_num    <= data_num_in;
                        r_command     <= command_in;
                        r_ptr         <= ptr_in;
                        r_mask        <= engine_mask_in;
                        r_done_status <= '0;
                        r_timeout     <= 1'b0;
                        r_cycles      <= '0;
                        r_run_cnt     <= '0;
                    end
                end
                S_KICK: begin
                    r_done_status <= w_done_acc;
                    r_cycles      <= sat_inc(r_cycles);
                end
                S_RUN: begin
                    r_done_status <= w_done_acc;
                    r_cycles      <= sat_inc(r_cycles);
                    if (WDOG_EN) begin
                        r_run_cnt <= r_run_cnt + 32'd1;
                    end
                    if (!w_all_done && w_wdog_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axonerve_kernel_ctrl.sv
// Bench for axonerve_kernel_ctrl: one hs-mode instance with a 100-cycle
// watchdog and one chain-mode instance without watchdog.  Expected timing is
// derived from per-engine done offsets relative to the start cycle.
module tb_axonerve_kernel_ctrl;

    localparam int NE = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   dly[NE];

    logic          h_start, h_cont, h_idle, h_ready, h_done, h_to;
    logic [NE-1:0] h_mask, h_kick, h_edone, h_dstat;
    logic [31:0]   h_dn, h_cmd, h_dnq, h_cmdq;
    logic [63:0]   h_ptr, h_ptrq, h_cc;

    logic          c_start, c_cont, c_idle, c_ready, c_done, c_to;
    logic [NE-1:0] c_mask, c_kick, c_edone, c_dstat;
    logic [31:0]   c_dn, c_cmd, c_dnq, c_cmdq;
    logic [63:0]   c_ptr, c_ptrq, c_cc;

    axonerve_kernel_ctrl #(.NUM_ENGINES(NE), .CHAIN_MODE(0), .CYC_W(64), .TIMEOUT_CYCLES(TO)) dut_hs (
        .ap_clk(clk), .areset(rst), .ap_start(h_start), .ap_continue(h_cont),
        .ap_idle(h_idle), .ap_ready(h_ready), .ap_done(h_done),
        .engine_mask_in(h_mask), .data_num_in(h_dn), .command_in(h_cmd), .ptr_in(h_ptr),
        .data_num_q(h_dnq), .command_q(h_cmdq), .ptr_q(h_ptrq),
        .engine_kick(h_kick), .engine_done(h_edone), .done_status(h_dstat),
        .timeout_err(h_to), .cycle_count(h_cc)
    );

    axonerve_kernel_ctrl #(.NUM_ENGINES(NE), .CHAIN_MODE(1), .CYC_W(64), .TIMEOUT_CYCLES(0)) dut_ch (
        .ap_clk(clk), .areset(rst), .ap_start(c_start), .ap_continue(c_cont),
        .ap_idle(c_idle), .ap_ready(c_ready), .ap_done(c_done),
        .engine_mask_in(c_mask), .data_num_in(c_dn), .command_in(c_cmd), .ptr_in(c_ptr),
        .data_num_q(c_dnq), .command_q(c_cmdq), .ptr_q(c_ptrq),
        .engine_kick(c_kick), .engine_done(c_edone), .done_status(c_dstat),
        .timeout_err(c_to), .cycle_count(c_cc)
    );

    // Offset (from the start cycle) of the first cycle showing ap_done.
    // A run finishes one cycle after the last masked done pulse, but no
    // earlier than offset 3; with a watchdog limit it gives up after limit
    // RUN cycles (offsets 2..limit+1).
    function automatic int model_done_off(input logic [NE-1:0] mask, input int limit, output bit to_o);
        int last;
        last = 2;
        to_o = 1'b0;
        if (mask == '0) return 1;
        for (int i = 0; i < NE; i++) begin
            if (mask[i]) begin
                if (dly[i] < 0) last = 1000000;
                else if (dly[i] > last) last = dly[i];
            end
        end
        if (limit != 0 && last > limit + 1) begin
            to_o = 1'b1;
            return limit + 2;
        end
        return last + 1;
    endfunction

    // Engines whose done pulse landed in KICK or RUN (offsets 1..dn-1).
    function automatic logic [NE-1:0] model_status(input logic [NE-1:0] mask, input int dn);
        logic [NE-1:0] s;
        s = '0;
        for (int i = 0; i < NE; i++)
            if (mask[i] && dly[i] >= 1 && dly[i] <= dn - 1) s[i] = 1'b1;
        return s;
    endfunction

    task automatic hs_run(input string tag, input logic [NE-1:0] mask, input bit hold, input bit reedge);
        bit            to_exp;
        bit            re;
        int            dn;
        logic [31:0]   a_dn, a_cmd;
        logic [63:0]   a_ptr;
        logic [NE-1:0] ds_exp, w_kick;
        logic [NE+2:0] got, want;
        dn = model_done_off(mask, TO, to_exp);
        ds_exp = model_status(mask, dn);
        re = reedge && hold && (dn >= 6);
        @(negedge clk);
        checks++;
        if (h_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_before_start got %b want 1", tag, h_idle);
        end
        a_dn = $urandom; a_cmd = $urandom; a_ptr = {$urandom, $urandom};
        h_dn = a_dn; h_cmd = a_cmd; h_ptr = a_ptr; h_mask = mask;
        h_start = 1'b1; h_edone = '0; h_cont = 1'b0;
        for (int o = 1; o <= dn + 3; o++) begin
            @(negedge clk);
            w_kick = (o == 1) ? mask : {NE{1'b0}};
            want = {(o >= dn + 1), (o == 1), (o == dn), w_kick};
            got  = {h_idle, h_ready, h_done, h_kick};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s off=%0d idle/ready/done/kick got %b want %b", tag, o, got, want);
            end
            h_start = hold && !(re && o == 3) && (o != dn + 3);
            h_dn = $urandom; h_cmd = $urandom; h_ptr = {$urandom, $urandom}; h_mask = NE'($urandom);
            h_cont = 1'($urandom);
            for (int i = 0; i < NE; i++)
                h_edone[i] = mask[i] ? ((dly[i] == o) || (dly[i] >= 1 && o > dly[i] && $urandom_range(0, 4) == 0))
                                     : ($urandom_range(0, 3) == 0);
        end
        checks++;
        if (h_cc !== 64'(dn - 1) || h_dstat !== ds_exp || h_to !== to_exp) begin
            errors++;
            $display("FAIL %s results cc=%0d status=%b to=%b want cc=%0d status=%b to=%b",
                     tag, h_cc, h_dstat, h_to, dn - 1, ds_exp, to_exp);
        end
        checks++;
        if (h_dnq !== a_dn || h_cmdq !== a_cmd || h_ptrq !== a_ptr) begin
            errors++;
            $display("FAIL %s args got %h/%h/%h want %h/%h/%h", tag, h_dnq, h_cmdq, h_ptrq, a_dn, a_cmd, a_ptr);
        end
    endtask

    task automatic ch_run(input string tag, input logic [NE-1:0] mask, input int wait_c, input bit keep);
        bit            to_exp;
        int            dn, last;
        logic [31:0]   a_dn, a_cmd;
        logic [63:0]   a_ptr;
        logic [NE-1:0] ds_exp, w_kick;
        logic [NE+2:0] got, want;
        dn = model_done_off(mask, 0, to_exp);
        ds_exp = model_status(mask, dn);
        last = keep ? dn + wait_c : dn + wait_c + 3;
        @(negedge clk);
        checks++;
        if (c_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_before_start got %b want 1", tag, c_idle);
        end
        a_dn = $urandom; a_cmd = $urandom; a_ptr = {$urandom, $urandom};
        c_dn = a_dn; c_cmd = a_cmd; c_ptr = a_ptr; c_mask = mask;
        c_start = 1'b1; c_edone = '0; c_cont = 1'($urandom);
        for (int o = 1; o <= last; o++) begin
            @(negedge clk);
            w_kick = (o == 1) ? mask : {NE{1'b0}};
            want = {(o >= dn + wait_c + 1), (o == 1), (o >= dn && o <= dn + wait_c), w_kick};
            got  = {c_idle, c_ready, c_done, c_kick};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s off=%0d idle/ready/done/kick got %b want %b", tag, o, got, want);
            end
            if (keep && o >= dn) c_start = 1'b1;
            else if (o <= dn + wait_c - 1) c_start = 1'($urandom);
            else c_start = 1'b0;
            if (o < dn) c_cont = 1'($urandom);
            else if (o == dn + wait_c) c_cont = 1'b1;
            else if (o > dn + wait_c) c_cont = 1'($urandom);
            else c_cont = 1'b0;
            c_dn = $urandom; c_cmd = $urandom; c_ptr = {$urandom, $urandom}; c_mask = NE'($urandom);
            for (int i = 0; i < NE; i++)
                c_edone[i] = mask[i] ? ((dly[i] == o) || (dly[i] >= 1 && o > dly[i] && $urandom_range(0, 4) == 0))
                                     : ($urandom_range(0, 3) == 0);
        end
        checks++;
        if (c_cc !== 64'(dn - 1) || c_dstat !== ds_exp || c_to !== 1'b0) begin
            errors++;
            $display("FAIL %s results cc=%0d status=%b to=%b want cc=%0d status=%b to=0",
                     tag, c_cc, c_dstat, c_to, dn - 1, ds_exp);
        end
        checks++;
        if (c_dnq !== a_dn || c_cmdq !== a_cmd || c_ptrq !== a_ptr) begin
            errors++;
            $display("FAIL %s args got %h/%h/%h want %h/%h/%h", tag, c_dnq, c_cmdq, c_ptrq, a_dn, a_cmd, a_ptr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (h_idle !== 1'b1 || h_ready !== 1'b0 || h_done !== 1'b0 || h_kick !== '0 || h_dstat !== '0 ||
            h_to !== 1'b0 || h_cc !== '0 || h_dnq !== '0 || h_cmdq !== '0 || h_ptrq !== '0) begin
            errors++;
            $display("FAIL reset_hs idle=%b ready=%b done=%b kick=%b status=%b to=%b cc=%0d want 1/0/0/0/0/0/0",
                     h_idle, h_ready, h_done, h_kick, h_dstat, h_to, h_cc);
        end
        checks++;
        if (c_idle !== 1'b1 || c_ready !== 1'b0 || c_done !== 1'b0 || c_kick !== '0 || c_dstat !== '0 ||
            c_to !== 1'b0 || c_cc !== '0 || c_dnq !== '0 || c_cmdq !== '0 || c_ptrq !== '0) begin
            errors++;
            $display("FAIL reset_ch idle=%b ready=%b done=%b kick=%b status=%b to=%b cc=%0d want 1/0/0/0/0/0/0",
                     c_idle, c_ready, c_done, c_kick, c_dstat, c_to, c_cc);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (h_idle !== 1'b1 || c_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_release idle got %b/%b want 1/1", h_idle, c_idle);
        end
    endtask

    task automatic test_hs_basic();
        dly = '{5, 9, 0, 7};
        hs_run("hs_basic", 4'b1011, 1'b0, 1'b0);
    endtask

    task automatic test_mask_zero();
        dly = '{3, 3, 3, 3};
        hs_run("hs_mask_zero", 4'b0000, 1'b0, 1'b0);
        ch_run("ch_mask_zero", 4'b0000, 2, 1'b0);
    endtask

    task automatic test_min_latency();
        dly = '{2, 2, 2, 2};
        hs_run("hs_min_lat", 4'b1111, 1'b0, 1'b0);
        dly = '{1, 1, 2, 1};
        hs_run("hs_done_in_kick", 4'b1111, 1'b0, 1'b0);
    endtask

    task automatic test_hs_random();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NE; i++) dly[i] = $urandom_range(1, 15);
            hs_run("hs_random", NE'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        dly = '{4, 6, -1, 0};
        hs_run("hs_timeout_stuck", 4'b0111, 1'b0, 1'b0);
        dly = '{3, 5, 8, 6};
        hs_run("hs_after_timeout", 4'b1111, 1'b0, 1'b0);
        dly = '{101, 5, 7, 3};
        hs_run("hs_done_at_limit", 4'b1111, 1'b0, 1'b0);
        dly = '{102, 5, 7, 3};
        hs_run("hs_done_past_limit", 4'b1111, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        dly = '{8, 10, 6, 12};
        hs_run("hs_hold_reedge", 4'b1011, 1'b1, 1'b1);
        dly = '{4, 3, 9, 5};
        hs_run("hs_hold", 4'b0110, 1'b1, 1'b0);
        dly = '{2, 7, 3, 4};
        hs_run("hs_b2b_next", 4'b1101, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [NE-1:0] mask;
        mask = 4'b0111;
        @(negedge clk);
        h_mask = mask; h_start = 1'b1; h_edone = '0;
        h_dn = $urandom; h_cmd = $urandom; h_ptr = {$urandom, $urandom};
        for (int o = 1; o <= 8; o++) begin
            @(negedge clk);
            h_start = 1'b0;
            h_edone = {1'b0, 1'b0, 1'b0 , 1'b0};
            h_edone[0] = (o == 3);
            h_edone[1] = (o == 5);
            if (o == 8) rst = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (h_idle !== 1'b1 || h_ready !== 1'b0 || h_done !== 1'b0 || h_kick !== '0 || h_dstat !== '0 ||
            h_to !== 1'b0 || h_cc !== '0 || h_dnq !== '0 || h_cmdq !== '0 || h_ptrq !== '0) begin
            errors++;
            $display("FAIL reset_abort idle=%b ready=%b done=%b kick=%b status=%b to=%b cc=%0d want 1/0/0/0/0/0/0",
                     h_idle, h_ready, h_done, h_kick, h_dstat, h_to, h_cc);
        end
        rst = 1'b0;
        h_edone = '0;
        @(negedge clk);
        h_edone[2] = 1'b1;
        for (int o = 11; o <= 16; o++) begin
            @(negedge clk);
            h_edone = '0;
            checks++;
            if ({h_idle, h_ready, h_done, h_kick} !== {1'b1, 1'b0, 1'b0, 4'b0000} || h_dstat !== '0) begin
                errors++;
                $display("FAIL reset_late_done off=%0d idle/ready/done/kick got %b status=%b want 1000000 0000",
                         o, {h_idle, h_ready, h_done, h_kick}, h_dstat);
            end
        end
    endtask

    task automatic test_chain_continue();
        dly = '{3, 6, 4, 5};
        ch_run("ch_wait20_keep", 4'b1111, 20, 1'b1);
        dly = '{2, 9, 5, 3};
        ch_run("ch_b2b", 4'b1010, 3, 1'b0);
        dly = '{2, 2, 2, 2};
        ch_run("ch_cont_immediate", 4'b0101, 0, 1'b0);
    endtask

    task automatic test_chain_random();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NE; i++) dly[i] = $urandom_range(1, 12);
            ch_run("ch_random", NE'($urandom), $urandom_range(0, 6), 1'($urandom));
        end
        c_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        h_start = 1'b0; h_cont = 1'b0; h_mask = '0; h_edone = '0; h_dn = '0; h_cmd = '0; h_ptr = '0;
        c_start = 1'b0; c_cont = 1'b0; c_mask = '0; c_edone = '0; c_dn = '0; c_cmd = '0; c_ptr = '0;
        test_reset();
        test_hs_basic();
        test_mask_zero();
        test_min_latency();
        test_hs_random();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_chain_continue();
        test_chain_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axonerve_kernel_ctrl.md
Name: axonerve_kernel_ctrl

Overview:
Parametrised kernel control sequencer for Axonerve SDAccel RTL kernels, the successor to the single-engine ap_start/ap_idle/ap_done logic. It latches scalar arguments, kicks up to NUM_ENGINES engines (wordcount, KVS, etc.) selected by a mask, and aggregates their done pulses. It supports both ap_ctrl_hs and ap_ctrl_chain handshakes, a run-cycle counter and an optional watchdog timeout. It sits between the SDx control interface and the engine tops inside the kernel wrapper.

Parameters:
NUM_ENGINES, 4, number of engine kick/done channels (1..16)
CHAIN_MODE, 0, 0 = ap_ctrl_hs (edge-triggered start, 1-cycle ap_done); 1 = ap_ctrl_chain (level start, ap_done held until ap_continue)
CYC_W, 64, width of cycle_count
TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
ap_clk  in  1  kernel clock
areset  in  1  synchronous active-high reset
ap_start  in  1  SDx start
ap_continue  in  1  SDx continue; used only when CHAIN_MODE=1
ap_idle  out  1  kernel idle
ap_ready  out  1  arguments consumed (1-cycle pulse)
ap_done  out  1  run complete
engine_mask_in  in  NUM_ENGINES  engines to run, sampled at start
data_num_in  in  32  scalar argument
command_in  in  32  scalar argument
ptr_in  in  64  global memory pointer argument
data_num_q  out  32  latched data_num
command_q  out  32  latched command
ptr_q  out  64  latched ptr
engine_kick  out  NUM_ENGINES  one-cycle kick per enabled engine
engine_done  in  NUM_ENGINES  one-cycle done pulse per engine
done_status  out  NUM_ENGINES  sticky per-engine done flags for the current run
timeout_err  out  1  sticky; watchdog expired in the last run
cycle_count  out  CYC_W  cycles spent in KICK+RUN for the last run

Behaviour:
- Reset values: state=IDLE, ap_idle=1, ap_ready=0, ap_done=0, engine_kick=0, done_status=0, timeout_err=0, cycle_count=0, all *_q=0, mask=0, ap_start_r=0. A reset in any state aborts the run immediately; no kick or done is emitted afterwards.
- start_ev: ap_start & ~ap_start_r when CHAIN_MODE=0; ap_start when CHAIN_MODE=1. ap_start_r is always registered.
- IDLE: ap_idle=1. On start_ev, the block latches data_num/command/ptr, mask := engine_mask_in, clears done_status/timeout_err/cycle_count and deasserts ap_idle on the next edge.
  - mask==0: goes to DONE.
  - Otherwise: goes to KICK.
- KICK (1 cycle): engine_kick=mask, ap_ready=1, cycle_count increments, then RUN. ap_ready also pulses for one cycle on the IDLE->DONE path for mask==0.
- RUN:
  - done_status |= engine_done & mask, also sampled in KICK. Done pulses from unmasked engines are ignored. Repeat pulses are harmless.
  - cycle_count increments each cycle and saturates at all-ones.
  - Go to DONE on the edge where (done_status | engine_done) & mask == mask. ap_done asserts 1 cycle after the final done pulse is sampled.
  - Watchdog: if TIMEOUT_CYCLES!=0 and the RUN cycle counter reaches TIMEOUT_CYCLES, set timeout_err and go to DONE. Completion in the same cycle takes priority and leaves timeout_err=0.
- DONE:
  - CHAIN_MODE=0: ap_done=1 for exactly 1 cycle, then IDLE with ap_idle=1 on the following cycle.
  - CHAIN_MODE=1: ap_done is held until sampled ap_continue=1, then IDLE. ap_continue in other states is ignored.
- ap_start while not in IDLE is ignored; no queuing.
  - hs mode: ap_start held high across a run does not retrigger; a fresh rising edge is required.
  - chain mode: ap_start high in IDLE restarts on the next cycle.
- *_q, done_status, cycle_count and timeout_err hold their values after DONE until the next start_ev.
- Minimum latency, start sampled at T: kick at T+1, ap_done at T+3 when all done pulses arrive at T+2.

Test Plan:
- hs, NUM_ENGINES=4, mask=4'b1011, start edge at T, dones on engines 0/1/3 at T+5/T+9/T+7 -> engine_kick=1011 at T+1, ap_ready at T+1, ap_done for 1 cycle at T+10, cycle_count=9, done_status=1011.
- mask=0 -> no kick, ap_ready pulse, ap_done 1 cycle, cycle_count=0, ap_idle back to 1.
- TIMEOUT_CYCLES=100, engine 2 never finishes -> timeout_err=1 and ap_done about 101 cycles after kick. A following run with all dones clears timeout_err.
- CHAIN_MODE=1, ap_continue held low for 20 cycles after completion -> ap_done stays 1 for 20 cycles, ap_idle=0. ap_continue=1 -> idle next cycle. ap_start held high -> back-to-back run starts.
- hs, ap_start held high through and after the run, spurious engine_done on an unmasked engine, second ap_start edge during RUN -> single run only, unmasked done ignored.
- areset asserted in RUN with 2 of 3 dones received -> all outputs return to reset values next cycle. A later done pulse causes no ap_done.
